// File: rtl/branch_resolve.sv
// branch_resolve: resolves BEQ/BNE/JMP, issues a one-cycle PC redirect and a
// FLUSH_CYCLES-long flush strobe, and keeps a saturating taken-branch count.
module branch_resolve #(
  parameter int ADDRSIZE = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                br_valid,
  output logic                br_ready,
  input  logic [1:0]          br_op,
  input  logic                eq,
  input  logic [ADDRSIZE-1:0] pc,
  input  logic [ADDRSIZE-1:0] offset,
  output logic                redirect_valid,
  output logic [ADDRSIZE-1:0] redirect_pc,
  output logic                flush,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    taken_count
);
  typedef enum logic {IDLE, FLUSH} state_t;
  localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic acc, taken;
  // flush and ready come straight from the state so reset drops them asynchronously
  assign br_ready = state == IDLE;
  assign flush = state == FLUSH;
  assign acc = br_valid & br_ready;
  always_comb taken = br_op == 2'b00 ? eq : br_op == 2'b01 ? !eq : br_op == 2'b10;
  always_comb begin
    state_nx = state;
    if (state == IDLE && acc && taken) state_nx = FLUSH;
    if (state == FLUSH && cnt == 4'd0) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      illegal_op <= 1'b0;
      taken_count <= '0;
    end else begin
      redirect_valid <= acc && taken;
      illegal_op <= acc && br_op == 2'b11;
      if (acc && taken) begin
        redirect_pc <= pc + offset;
        cnt <= FLUSH_LD;
        if (!(&taken_count)) taken_count <= taken_count + 1'b1;
      end else if (flush && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed steps with a redirect_pc scoreboard queue.
module tb_branch_resolve;
  logic clk = 0, reset_n = 0, br_valid = 0, eq = 0;
  logic [1:0] br_op = 0;
  logic [15:0] pc = 0, offset = 0;
  logic br_ready, redirect_valid, flush, illegal_op, br_ready2, rv2, flush2, ill2;
  logic [15:0] redirect_pc, rpc2, taken_count;
  logic [1:0] cnt2;
  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  always #5 clk = ~clk;

  branch_resolve dut (.clk(clk), .reset_n(reset_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_op(br_op), .eq(eq), .pc(pc), .offset(offset), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .illegal_op(illegal_op), .taken_count(taken_count));
  branch_resolve #(.CNT_W(2)) dut2 (.clk(clk), .reset_n(reset_n), .br_valid(br_valid),
    .br_ready(br_ready2), .br_op(br_op), .eq(eq), .pc(pc), .offset(offset),
    .redirect_valid(rv2), .redirect_pc(rpc2), .flush(flush2), .illegal_op(ill2),
    .taken_count(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic e,
                       input logic [15:0] p, input logic [15:0] o);
    br_valid = v; br_op = op; eq = e; pc = p; offset = o;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic outs(input string tag, input logic rdy, input logic rv, input logic fl,
                      input logic il);
    chk({tag, ".br_ready"}, br_ready, rdy);
    chk({tag, ".redirect_valid"}, redirect_valid, rv);
    chk({tag, ".flush"}, flush, fl);
    chk({tag, ".illegal_op"}, illegal_op, il);
  endtask

  always @(negedge clk) if (reset_n && redirect_valid) begin
    if (exp_q.size() == 0) chk("sb.unexpected_redirect", 1, 0);
    else chk("sb.redirect_pc", redirect_pc, exp_q.pop_front());
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    outs("reset", 1, 0, 0, 0);
    chk("reset.redirect_pc", redirect_pc, 0);
    chk("reset.taken_count", taken_count, 0);
    reset_n = 1;
    // BEQ taken
    drive(1, 2'b00, 1, 16'h0100, 16'h0010); exp_q.push_back(16'h0110);
    tick(); outs("beq.c1", 0, 1, 1, 0);
    chk("beq.taken_count", taken_count, 1);
    drive(0, 0, 0, 0, 0);
    tick(); outs("beq.c2", 0, 0, 1, 0);
    chk("beq.pc_hold", redirect_pc, 16'h0110);
    tick(); outs("beq.c3", 1, 0, 0, 0);
    // BNE not taken, back to back
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b01, 1, 16'h4000 + 16'(i), 16'h0020);
      chk("bne.ready_before", br_ready, 1);
      tick(); outs("bne", 1, 0, 0, 0);
    end
    chk("bne.taken_count", taken_count, 1);
    // wrap and negative offset
    drive(1, 2'b10, 0, 16'hFFF8, 16'h0010); exp_q.push_back(16'h0008);
    tick(); outs("wrap.c1", 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0); tick(); tick(); outs("wrap.idle", 1, 0, 0, 0);
    drive(1, 2'b00, 1, 16'h0010, 16'hFFF0); exp_q.push_back(16'h0000);
    tick(); outs("neg.c1", 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0); tick(); tick(); outs("neg.idle", 1, 0, 0, 0);
    chk("neg.taken_count", taken_count, 3);
    // branch held valid during flush
    drive(1, 2'b10, 0, 16'h2000, 16'h0004); exp_q.push_back(16'h2004);
    tick(); outs("hold.c1", 0, 1, 1, 0);
    drive(1, 2'b00, 1, 16'h3000, 16'h0008);
    tick(); outs("hold.c2", 0, 0, 1, 0);
    tick(); outs("hold.c3", 1, 0, 0, 0);
    exp_q.push_back(16'h3008);
    tick(); outs("hold.c4", 0, 1, 1, 0);
    chk("hold.taken_count", taken_count, 5);
    drive(0, 0, 0, 0, 0); tick(); tick(); outs("hold.idle", 1, 0, 0, 0);
    // reserved op and counter saturation
    drive(1, 2'b11, 1, 16'h5000, 16'h0010);
    tick(); outs("ill.c1", 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    tick(); outs("ill.c2", 1, 0, 0, 0);
    chk("ill.taken_count", taken_count, 5);
    chk("sat.cnt2", cnt2, 3);
    chk("sat.queue_empty", exp_q.size(), 0);
    // reset mid-flush
    drive(1, 2'b10, 0, 16'h6000, 16'h0002);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0);
    chk("rstmid.flush_before", flush, 1);
    exp_q.push_back(16'h6002);
    @(negedge clk); #1;
    reset_n = 0; #1;
    outs("rstmid", 1, 0, 0, 0);
    chk("rstmid.taken_count", taken_count, 0);
    chk("rstmid.redirect_pc", redirect_pc, 0);
    tick(); reset_n = 1;
    tick(); outs("rstmid.after", 1, 0, 0, 0);
    chk("end.queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
